// File: rtl/quad_encoder_ctrl.sv
// Rotary encoder front end: synchronised/debounced A, B and PB, detent counter with
// wrap or saturate, and short/long/double press classification.
module quad_encoder_ctrl #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned DEB_CYCLES  = 8,
    parameter int unsigned STEPS_DET   = 4,
    parameter int unsigned WRAP        = 1,
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned DBL_CYCLES  = 300
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             PB,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             step,
    output logic             dir,
    output logic             pb_valid,
    output logic [1:0]       pb_press_type
);

    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned ACC_W   = $clog2(STEPS_DET + 1) + 1;
    localparam int unsigned TMR_MAX = (LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    // Bit order {PB, A, B}; encoder idles high, button idles low.
    localparam logic [2:0] RST_VAL = 3'b011;

    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_DET);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic [CNT_W-1:0]        CNT_TOP = '1;

    localparam logic [TMR_W-1:0] TMR_TOP  = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] LONG_LIM = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] DBL_LIM  = TMR_W'(DBL_CYCLES - 1);

    localparam logic [1:0] TYPE_SHORT  = 2'b01;
    localparam logic [1:0] TYPE_LONG   = 2'b10;
    localparam logic [1:0] TYPE_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPressed,
        StHeld,
        StWait2,
        StPressed2
    } pb_state_e;

    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_filt;
    logic [DEB_W-1:0] r_deb [3];

    assign w_raw = {PB, A, B};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_filt  <= RST_VAL;
            for (int i = 0; i < 3; i++) r_deb[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb[i] <= '0;
                end else if (r_deb[i] == DEB_W'(DEB_CYCLES)) begin
                    r_filt[i] <= r_sync2[i];
                    r_deb[i]  <= '0;
                end else begin
                    r_deb[i] <= r_deb[i] + DEB_W'(1);
                end
            end
        end
    end

    // Position along the Gray cycle 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    logic [1:0]              w_ab_cur;
    logic [1:0]              r_ab_prev;
    logic [1:0]              w_delta;
    logic                    w_up;
    logic                    w_dn;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_step;
    logic                    w_step_nxt;
    logic                    r_dir;
    logic                    w_dir_nxt;

    assign w_ab_cur = r_filt[1:0];
    assign w_delta  = gray_pos(w_ab_cur) - gray_pos(r_ab_prev);
    assign w_up     = en && (w_delta == 2'd3);
    assign w_dn     = en && (w_delta == 2'd1);

    always_comb begin
        w_acc_sum  = r_acc;
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_step_nxt = 1'b0;
        w_dir_nxt  = r_dir;
        if (w_up) w_acc_sum = r_acc + ACC_ONE;
        if (w_dn) w_acc_sum = r_acc - ACC_ONE;
        if (clr) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
        end else if (w_up || w_dn) begin
            if (w_acc_sum == ACC_MAX) begin
                w_acc_nxt = '0;
                if (WRAP != 0 || r_cnt != CNT_TOP) begin
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = 1'b1;
                end
            end else if (w_acc_sum == ACC_MIN) begin
                w_acc_nxt = '0;
                if (WRAP != 0 || r_cnt != '0) begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = 1'b0;
                end
            end else begin
                w_acc_nxt = w_acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ab_prev <= RST_VAL[1:0];
            r_acc     <= '0;
            r_cnt     <= '0;
            r_step    <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_ab_prev <= w_ab_cur;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_step    <= w_step_nxt;
            r_dir     <= w_dir_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign step = r_step;
    assign dir  = r_dir;

    pb_state_e        r_state;
    pb_state_e        w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             r_pb_prev;
    logic             w_pb_rise;
    logic             w_pb_fall;
    logic             w_emit;
    logic [1:0]       w_emit_type;
    logic             r_pb_valid;
    logic [1:0]       r_pb_type;

    assign w_pb_rise = r_filt[2] & ~r_pb_prev;
    assign w_pb_fall = ~r_filt[2] & r_pb_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_type = TYPE_SHORT;
        if (en) begin
            unique case (r_state)
                StIdle: begin
                    if (w_pb_rise) w_state_nxt = StPressed;
                end
                StPressed: begin
                    if (w_pb_fall) begin
                        w_state_nxt = StWait2;
                    end else if (r_tmr == LONG_LIM) begin
                        w_state_nxt = StHeld;
                        w_emit      = 1'b1;
                        w_emit_type = TYPE_LONG;
                    end
                end
                StHeld: begin
                    if (w_pb_fall) w_state_nxt = StIdle;
                end
                StWait2: begin
                    // A second press landing on the timeout cycle is too late.
                    if (r_tmr == DBL_LIM) begin
                        w_state_nxt = StIdle;
                        w_emit      = 1'b1;
                        w_emit_type = TYPE_SHORT;
                    end else if (w_pb_rise) begin
                        w_state_nxt = StPressed2;
                    end
                end
                StPressed2: begin
                    if (w_pb_fall) begin
                        w_state_nxt = StIdle;
                        w_emit      = 1'b1;
                        w_emit_type = TYPE_DOUBLE;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end else begin
            w_state_nxt = StIdle;
        end
        if (!en || w_state_nxt != r_state) begin
            w_tmr_nxt = '0;
        end else if (r_tmr == TMR_TOP) begin
            w_tmr_nxt = r_tmr;
        end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_tmr      <= '0;
            r_pb_prev  <= RST_VAL[2];
            r_pb_valid <= 1'b0;
            r_pb_type  <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_pb_prev  <= r_filt[2];
            r_pb_valid <= w_emit;
            if (w_emit) r_pb_type <= w_emit_type;
        end
    end

    assign pb_valid      = r_pb_valid;
    assign pb_press_type = r_pb_type;

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Bench for quad_encoder_ctrl: directed cases plus random rotation/button traffic,
// checked every cycle against a delay-line + arithmetic reference model.
module tb_quad_encoder_ctrl;

    localparam int DEB   = 2;
    localparam int STEPS = 4;
    localparam int LONG  = 20;
    localparam int DBL   = 10;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int LAT   = 3 + DEB;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic en    = 1'b0;
    logic clr   = 1'b0;
    logic a_raw = 1'b1;
    logic b_raw = 1'b1;
    logic pb_raw = 1'b0;
    logic a_cl  = 1'b1;
    logic b_cl  = 1'b1;
    logic chk_on = 1'b0;

    logic [CW-1:0] cnt_w, cnt_s;
    logic          step_w, step_s, dir_w, dir_s, v_w, v_s;
    logic [1:0]    t_w, t_s;

    always #5 clk = ~clk;

    quad_encoder_ctrl #(
        .CNT_W(CW), .DEB_CYCLES(DEB), .STEPS_DET(STEPS), .WRAP(1),
        .LONG_CYCLES(LONG), .DBL_CYCLES(DBL)
    ) u_dut_wrap (
        .clk(clk), .rstn(rstn), .en(en), .A(a_raw), .B(b_raw), .PB(pb_raw), .clr(clr),
        .cnt(cnt_w), .step(step_w), .dir(dir_w), .pb_valid(v_w), .pb_press_type(t_w)
    );

    quad_encoder_ctrl #(
        .CNT_W(CW), .DEB_CYCLES(DEB), .STEPS_DET(STEPS), .WRAP(0),
        .LONG_CYCLES(LONG), .DBL_CYCLES(DBL)
    ) u_dut_sat (
        .clk(clk), .rstn(rstn), .en(en), .A(a_raw), .B(b_raw), .PB(pb_raw), .clr(clr),
        .cnt(cnt_s), .step(step_s), .dir(dir_s), .pb_valid(v_s), .pb_press_type(t_s)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_at(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Reference model. Filtered inputs are the clean raw inputs delayed by 2+DEB
    // cycles; the counter/FSM react one cycle after that.
    logic [2:0] hist [16];
    int m_cnt [2];
    int m_acc [2];
    int m_step [2];
    int m_dir [2];
    int ph, ts, m_valid, m_type, mcyc;

    initial begin : model
        logic [2:0] hc, hp;
        int d, q;
        bit up, rise, fall;
        mcyc = 16;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int i = 0; i < 16; i++) hist[i] = 3'b011;
                for (int k = 0; k < 2; k++) begin
                    m_cnt[k] = 0; m_acc[k] = 0; m_step[k] = 0; m_dir[k] = 0;
                end
                ph = 0; ts = 0; m_valid = 0; m_type = 0;
            end else begin
                hist[mcyc % 16] = {pb_raw, a_cl, b_cl};
                hc = hist[(mcyc - LAT) % 16];
                hp = hist[(mcyc - LAT - 1) % 16];
                d = (gpos(hc[1:0]) - gpos(hp[1:0]) + 4) % 4;
                q = (d == 3) ? 1 : ((d == 1) ? -1 : 0);
                for (int k = 0; k < 2; k++) begin
                    m_step[k] = 0;
                    if (clr) begin
                        m_cnt[k] = 0;
                        m_acc[k] = 0;
                    end else if (en && q != 0) begin
                        m_acc[k] += q;
                        if (m_acc[k] == STEPS || m_acc[k] == -STEPS) begin
                            up = (m_acc[k] > 0);
                            m_acc[k] = 0;
                            if (k == 0 || (up ? m_cnt[k] < CMAX : m_cnt[k] > 0)) begin
                                m_cnt[k] = (m_cnt[k] + (up ? 1 : CMAX)) % (CMAX + 1);
                                m_step[k] = 1;
                                m_dir[k] = up ? 1 : 0;
                            end
                        end
                    end
                end
                rise = hc[2] && !hp[2];
                fall = !hc[2] && hp[2];
                m_valid = 0;
                if (!en) begin
                    ph = 0;
                end else begin
                    case (ph)
                        0: if (rise) begin ph = 1; ts = mcyc; end
                        1: begin
                            if (fall) begin ph = 3; ts = mcyc; end
                            else if (mcyc - ts == LONG) begin ph = 2; m_valid = 1; m_type = 2; end
                        end
                        2: if (fall) ph = 0;
                        3: begin
                            if (mcyc - ts == DBL) begin ph = 0; m_valid = 1; m_type = 1; end
                            else if (rise) ph = 4;
                        end
                        default: if (fall) begin ph = 0; m_valid = 1; m_type = 3; end
                    endcase
                end
                mcyc++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cnt_wrap", int'(cnt_w), m_cnt[0]);
                chk("cnt_sat", int'(cnt_s), m_cnt[1]);
                chk("step_wrap", int'(step_w), m_step[0]);
                chk("step_sat", int'(step_s), m_step[1]);
                chk("dir_wrap", int'(dir_w), m_dir[0]);
                chk("dir_sat", int'(dir_s), m_dir[1]);
                chk("pbv_wrap", int'(v_w), m_valid);
                chk("pbv_sat", int'(v_s), m_valid);
                chk("type_wrap", int'(t_w), m_type);
                chk("type_sat", int'(t_s), m_type);
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        {a_cl, b_cl} = ab;
        a_raw = ab[1];
        b_raw = ab[0];
    endtask

    task automatic quarter(input bit up, input int hold);
        int p;
        p = gpos({a_cl, b_cl});
        p = up ? (p + 3) % 4 : (p + 1) % 4;
        set_ab(ab_at(p));
        cyc_wait(hold);
    endtask

    task automatic detent(input bit up);
        for (int i = 0; i < 4; i++) quarter(up, 4 + int'($urandom_range(0, 2)));
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            cyc_wait(1);
            pulses += int'(v_w);
        end
    endtask

    initial begin : main
        int p1, p2;
        bit rdir;
        cyc_wait(2);
        chk_on = 1'b1;
        chk("rst_cnt", int'(cnt_w), 0);
        chk("rst_type", int'(t_w), 0);
        cyc_wait(6);
        rstn = 1'b1;
        en   = 1'b1;
        cyc_wait(10);

        // One CW detent from 11 with exact output latency.
        for (int i = 0; i < 3; i++) quarter(1'b1, 4);
        quarter(1'b1, 0);
        cyc_wait(5);
        chk("t1_early_step", int'(step_w), 0);
        chk("t1_early_cnt", int'(cnt_w), 0);
        cyc_wait(1);
        chk("t1_step", int'(step_w), 1);
        chk("t1_cnt", int'(cnt_w), 1);
        chk("t1_dir", int'(dir_w), 1);
        cyc_wait(1);
        chk("t1_step_pulse", int'(step_w), 0);
        for (int i = 0; i < 15; i++) detent(1'b1);
        cyc_wait(10);
        chk("t1_wrap_cnt", int'(cnt_w), 0);
        chk("t2_sat_top", int'(cnt_s), 15);

        clr = 1'b1;
        cyc_wait(1);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) detent(1'b0);
        cyc_wait(10);
        chk("t2_wrap_ccw", int'(cnt_w), 13);
        chk("t2_sat_bottom", int'(cnt_s), 0);
        chk("t2_dir", int'(dir_w), 0);

        // Glitch shorter than the debounce window, then an illegal jump mid-detent.
        a_raw = ~a_cl;
        cyc_wait(1);
        a_raw = a_cl;
        cyc_wait(8);
        chk("t3_glitch", int'(cnt_w), 13);
        quarter(1'b1, 5);
        quarter(1'b1, 5);
        set_ab(~{a_cl, b_cl});
        cyc_wait(5);
        quarter(1'b1, 10);
        chk("t3_illegal", int'(cnt_w), 13);
        quarter(1'b1, 10);
        chk("t3_acc_kept", int'(cnt_w), 14);

        pb_raw = 1'b1;
        cyc_wait(5);
        pb_raw = 1'b0;
        watch(25, p1);
        chk("t4_short_n", p1, 1);
        chk("t4_short_type", int'(t_w), 1);
        pb_raw = 1'b1;
        watch(25, p1);
        pb_raw = 1'b0;
        watch(25, p2);
        chk("t4_long_n", p1 + p2, 1);
        chk("t4_long_type", int'(t_w), 2);

        pb_raw = 1'b1;
        cyc_wait(5);
        pb_raw = 1'b0;
        cyc_wait(4);
        pb_raw = 1'b1;
        watch(3, p1);
        pb_raw = 1'b0;
        watch(25, p2);
        chk("t5_pre", p1, 0);
        chk("t5_dbl_n", p2, 1);
        chk("t5_dbl_type", int'(t_w), 3);

        // clr on the very cycle a detent would register.
        for (int i = 0; i < 3; i++) quarter(1'b1, 4);
        quarter(1'b1, 0);
        cyc_wait(4);
        clr = 1'b1;
        cyc_wait(1);
        clr = 1'b0;
        chk("t6_clr_cnt", int'(cnt_w), 0);
        chk("t6_clr_step", int'(step_w), 0);
        cyc_wait(5);

        pb_raw = 1'b1;
        cyc_wait(10);
        rstn = 1'b0;
        #1;
        chk("t6_rst_type", int'(t_w), 0);
        chk("t6_rst_cnt", int'(cnt_w), 0);
        pb_raw = 1'b0;
        cyc_wait(4);
        rstn = 1'b1;
        watch(30, p1);
        chk("t6_no_event", p1, 0);

        rdir = 1'b1;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    if ($urandom_range(0, 9) < 2) rdir = ~rdir;
                    if (r < 70) begin
                        quarter(rdir, 4 + int'($urandom_range(0, 3)));
                    end else if (r < 78) begin
                        set_ab(~{a_cl, b_cl});
                        cyc_wait(4 + int'($urandom_range(0, 3)));
                    end else if (r < 86) begin
                        if ($urandom_range(0, 1) == 1) a_raw = ~a_cl;
                        else b_raw = ~b_cl;
                        cyc_wait(1);
                        a_raw = a_cl;
                        b_raw = b_cl;
                        cyc_wait(5);
                    end else if (r < 93) begin
                        clr = 1'b1;
                        cyc_wait(1 + int'($urandom_range(0, 1)));
                        clr = 1'b0;
                    end else begin
                        en = 1'b0;
                        cyc_wait(1 + int'($urandom_range(0, 29)));
                        en = 1'b1;
                    end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    pb_raw = 1'b1;
                    cyc_wait(3 + int'($urandom_range(0, 27)));
                    pb_raw = 1'b0;
                    cyc_wait(3 + int'($urandom_range(0, 13)));
                end
            end
        join
        cyc_wait(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
